// File: rtl/tx_iq_serializer.sv
// Pair FIFO + I/Q interleaver feeding the TX CIC as an Avalon-ST stream.
// Optional build macro TX_IQ_SER_ZERO_FILL_EN: emit flagged zero pairs on FIFO starvation.
module tx_iq_serializer #(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] s_i_data,
   input  logic [DATA_W-1:0] s_q_data,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic              tx_enable,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_startofpacket,
   output logic              out_endofpacket,
   output logic [1:0]        out_error,
   output logic [15:0]       underflow_count,
   input  logic              underflow_clr
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD_I = 2'd1,
      HOLD_Q = 2'd2
   } state_t;

   state_t state;

   // Pair storage, {I,Q} per entry; pointers carry one wrap bit.
   logic [2*DATA_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [AW:0]         wr_ptr;
   logic [AW:0]         rd_ptr;
   logic [2*DATA_W-1:0] rd_pair;
   logic                full;
   logic                empty;
   logic                push;
   logic                pop;
   logic                can_start;
   logic                uf_event;
   logic [DATA_W-1:0]   q_hold;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_pair = fifo_mem[rd_ptr[AW-1:0]];

   // Both ports: a transfer happens on the rising edge where valid && ready.
   // Upstream ready depends only on tx_enable and the pointer state, never on out_ready;
   // the output holds data/SOP/EOP/error stable while out_valid && !out_ready.
   assign s_ready = tx_enable && !full;
   assign push    = s_valid && s_ready;

   // A new pair may be started from IDLE, or back-to-back as the Q beat leaves.
   assign can_start = (state != HOLD_I && state != HOLD_Q) || (state == HOLD_Q && out_ready);
   assign pop       = can_start && tx_enable && !empty;
   assign uf_event  = can_start && tx_enable && empty && out_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (!tx_enable) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr[AW-1:0]] <= {s_i_data, s_q_data};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state             <= IDLE;
         out_valid         <= 1'b0;
         out_data          <= '0;
         q_hold            <= '0;
         out_startofpacket <= 1'b0;
         out_endofpacket   <= 1'b0;
         out_error         <= 2'b00;
      end else if (can_start) begin
         if (pop) begin
            state             <= HOLD_I;
            out_valid         <= 1'b1;
            out_data          <= rd_pair[2*DATA_W-1:DATA_W];
            q_hold            <= rd_pair[DATA_W-1:0];
            out_startofpacket <= 1'b1;
            out_endofpacket   <= 1'b0;
            out_error         <= 2'b00;
         end
`ifdef TX_IQ_SER_ZERO_FILL_EN
         else if (uf_event) begin
            // Starved: keep the CIC input rate continuous with a flagged zero pair.
            state             <= HOLD_I;
            out_valid         <= 1'b1;
            out_data          <= '0;
            q_hold            <= '0;
            out_startofpacket <= 1'b1;
            out_endofpacket   <= 1'b0;
            out_error         <= 2'b01;
         end
`endif
         else begin
            state             <= IDLE;
            out_valid         <= 1'b0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
            out_error         <= 2'b00;
         end
      end else if (state == HOLD_I && out_ready) begin
         // Q comes from the hold register, so it completes even with tx_enable low.
         state             <= HOLD_Q;
         out_data          <= q_hold;
         out_startofpacket <= 1'b0;
         out_endofpacket   <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         underflow_count <= 16'h0000;
      end else if (underflow_clr) begin
         underflow_count <= 16'h0000;
      end else if (uf_event && underflow_count != 16'hFFFF) begin
         underflow_count <= underflow_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_tx_iq_serializer.sv
// Bench for tx_iq_serializer: random and directed stimulus against a pair/beat queue model.
// Build with +define+TX_IQ_SER_ZERO_FILL_EN to exercise the zero-fill variant.
module tb_tx_iq_serializer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              reset_n;
  logic [DATA_W-1:0] s_i_data;
  logic [DATA_W-1:0] s_q_data;
  logic              s_valid;
  logic              s_ready;
  logic              tx_enable;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_startofpacket;
  logic              out_endofpacket;
  logic [1:0]        out_error;
  logic [15:0]       underflow_count;
  logic              underflow_clr;

  tx_iq_serializer #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .s_i_data         (s_i_data),
    .s_q_data         (s_q_data),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .tx_enable        (tx_enable),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_startofpacket(out_startofpacket),
    .out_endofpacket  (out_endofpacket),
    .out_error        (out_error),
    .underflow_count  (underflow_count),
    .underflow_clr    (underflow_clr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: queued pairs and the beats still owed to the output
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
    logic [1:0]        err;
  } beat_t;

  logic [2*DATA_W-1:0] exp_q[$];
  beat_t               beat_q[$];
  int unsigned         m_count;
  int                  n_cmp;
  int                  n_bad;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_pair_beats(input logic [DATA_W-1:0] i, input logic [DATA_W-1:0] q,
                                 input logic [1:0] err);
    beat_t b;
    b = '{data: i, sop: 1'b1, eop: 1'b0, err: err};
    beat_q.push_back(b);
    b = '{data: q, sop: 1'b0, eop: 1'b1, err: err};
    beat_q.push_back(b);
  endtask

  // One rising edge of the behaviour: transfer, start a pair or underflow, then FIFO update.
  task automatic model_edge(input logic v, input logic [DATA_W-1:0] i, input logic [DATA_W-1:0] q,
                            input logic te, input logic ordy, input logic clr);
    logic                push_ok;
    logic                free;
    logic                had_pair;
    logic [2*DATA_W-1:0] p;
    push_ok  = v && te && (exp_q.size() < DEPTH);
    free     = (beat_q.size() == 0) || (beat_q.size() == 1 && ordy);
    had_pair = (exp_q.size() > 0);
    if (ordy && beat_q.size() > 0) void'(beat_q.pop_front());
    if (free && te && had_pair) begin
      p = exp_q.pop_front();
      push_pair_beats(p[2*DATA_W-1:DATA_W], p[DATA_W-1:0], 2'b00);
    end else if (free && te && ordy) begin
      if (m_count < 32'd65535) m_count++;
`ifdef TX_IQ_SER_ZERO_FILL_EN
      push_pair_beats('0, '0, 2'b01);
`endif
    end
    if (clr) m_count = 0;
    if (!te) exp_q.delete();
    else if (push_ok) exp_q.push_back({i, q});
  endtask

  task automatic check_outputs();
    check_eq("out_valid", out_valid, (beat_q.size() > 0));
    if (beat_q.size() > 0) begin
      check_eq("out_data", out_data, beat_q[0].data);
      check_eq("sop", out_startofpacket, beat_q[0].sop);
      check_eq("eop", out_endofpacket, beat_q[0].eop);
      check_eq("out_error", out_error, beat_q[0].err);
    end else begin
      check_eq("sop_idle", out_startofpacket, 1'b0);
      check_eq("eop_idle", out_endofpacket, 1'b0);
      check_eq("err_idle", out_error, 2'b00);
    end
    check_eq("underflow_count", underflow_count, m_count);
  endtask

  // driver: apply inputs, check s_ready, clock, advance model, check outputs
  task automatic drive(input logic v, input logic [DATA_W-1:0] i, input logic [DATA_W-1:0] q,
                       input logic te, input logic ordy, input logic clr);
    s_valid       = v;
    s_i_data      = i;
    s_q_data      = q;
    tx_enable     = te;
    out_ready     = ordy;
    underflow_clr = clr;
    #2;
    check_eq("s_ready", s_ready, te && (exp_q.size() < DEPTH));
    @(posedge clk);
    model_edge(v, i, q, te, ordy, clr);
    #1;
    check_outputs();
  endtask

  task automatic idle_cycles(input int n, input logic te, input logic ordy);
    for (int k = 0; k < n; k++) drive(1'b0, '0, '0, te, ordy, 1'b0);
  endtask

  task automatic check_reset_values();
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_data", out_data, 16'h0000);
    check_eq("rst_sop", out_startofpacket, 1'b0);
    check_eq("rst_eop", out_endofpacket, 1'b0);
    check_eq("rst_err", out_error, 2'b00);
    check_eq("rst_count", underflow_count, 16'h0000);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_count = 0;
    reset_n = 1'b0;
    s_valid = 1'b0;
    s_i_data = '0;
    s_q_data = '0;
    tx_enable = 1'b0;
    out_ready = 1'b0;
    underflow_clr = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    check_eq("rst_s_ready", s_ready, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // two pairs with downstream always ready
    drive(1'b1, 16'h1234, 16'h8765, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 16'h0001, 16'hFFFF, 1'b1, 1'b1, 1'b0);
    idle_cycles(6, 1'b1, 1'b1);
    idle_cycles(3, 1'b0, 1'b1);

    // fill while stalled, hold the first I for 10 cycles, then drain
    for (int k = 0; k < 6; k++)
      drive(1'b1, DATA_W'($urandom), DATA_W'($urandom), 1'b1, 1'b0, 1'b0);
    check_eq("full_s_ready", s_ready, 1'b0);
    idle_cycles(10, 1'b1, 1'b0);
    idle_cycles(12, 1'b1, 1'b1);
    idle_cycles(3, 1'b0, 1'b1);

    // starvation with clean counter
    drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
    idle_cycles(6, 1'b1, 1'b1);
    idle_cycles(3, 1'b0, 1'b1);

    // tx_enable dropped in HOLD_I with two pairs queued
    for (int k = 0; k < 3; k++)
      drive(1'b1, DATA_W'($urandom), DATA_W'($urandom), 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++)
      drive(1'b1, DATA_W'($urandom), DATA_W'($urandom), 1'b0, 1'b1, 1'b0);
    check_eq("flush_empty", exp_q.size() == 0 && s_ready == 1'b0, 1'b1);

    // random traffic
    for (int k = 0; k < 3000; k++)
      drive(($urandom % 4) != 0, DATA_W'($urandom), DATA_W'($urandom),
            ($urandom % 16) != 0, ($urandom % 4) != 0, ($urandom % 64) == 0);
    idle_cycles(3, 1'b0, 1'b1);

`ifndef TX_IQ_SER_ZERO_FILL_EN
    // saturate the counter, then clear on an increment cycle
    drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
    idle_cycles(65540, 1'b1, 1'b1);
    check_eq("sat_count", underflow_count, 16'hFFFF);
    drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
    check_eq("clr_wins", underflow_count, 16'h0000);
`endif
    idle_cycles(3, 1'b0, 1'b1);

    // asynchronous reset while a Q beat is pending
    drive(1'b1, 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 16'h1111, 16'h2222, 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    check_eq("pre_rst_eop", out_endofpacket, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values();
    exp_q.delete();
    beat_q.delete();
    m_count = 0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 16'h0F0F, 16'hF0F0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    check_eq("post_rst_sop", out_startofpacket, 1'b1);
    check_eq("post_rst_data", out_data, 16'h0F0F);
    idle_cycles(4, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
